// File: rtl/truth_table_sequencer.sv
// Exhaustive 16-vector truth-table sequencer for a 4-input, 3-output
// combinational datapath. Each vector is applied, allowed to settle for
// SETTLE_CYCLES cycles, then {f,g,h} is captured into a 16-entry result table.
// Optional feature: define TTS_SIGNATURE_EN to build the 12-bit running
// signature register; otherwise sig is tied to zero.
module truth_table_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       f,
    input  logic       g,
    input  logic       h,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       busy,
    output logic       done,
    input  logic [3:0] rd_addr,
    output logic [2:0] rd_data,
    output logic [11:0] sig
);

    typedef enum logic [2:0] {
        StIdle,
        StApply,
        StSettle,
        StCapture,
        StDone
    } state_e;

    // Counter preload so that SETTLE lasts exactly SETTLE_CYCLES cycles.
    localparam logic [3:0] SettleLoad =
        (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);

    state_e     state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic       cap_we;
    logic [2:0] tbl_q [16];

    // Control state registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= 4'd0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; abort beats start and every in-scan transition.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        cap_we  = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (start) begin
                    state_d = StApply;
                    idx_d   = 4'd0;
                end
            end
            StApply: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (SETTLE_CYCLES == 0) begin
                    state_d = StCapture;
                end else begin
                    state_d = StSettle;
                    cnt_d   = SettleLoad;
                end
            end
            StSettle: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (cnt_q == 4'd0) begin
                    state_d = StCapture;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StCapture: begin
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    cap_we = 1'b1;
                    if (idx_q == 4'd15) begin
                        state_d = StDone;
                    end else begin
                        state_d = StApply;
                        idx_d   = idx_q + 4'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Status and vector outputs decoded from the current state.
    always_comb begin
        busy = (state_q == StApply) || (state_q == StSettle) || (state_q == StCapture);
        done = (state_q == StDone);
        {a, b, c, d} = busy ? idx_q : 4'd0;
    end

    // Result table: captured on the edge leaving CAPTURE, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                tbl_q[i] <= 3'd0;
            end
        end else if (cap_we) begin
            tbl_q[idx_q] <= {f, g, h};
        end
    end

    // Registered read port; a same-edge write returns the previous contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= 3'd0;
        end else begin
            rd_data <= tbl_q[rd_addr];
        end
    end

`ifdef TTS_SIGNATURE_EN
    logic [11:0] sig_q;
    logic        sig_clr;

    // A scan launch happens only from IDLE/DONE with start and no abort.
    assign sig_clr = !busy && start && !abort;

    // Rotate-and-xor signature over every captured result.
    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= 12'h000;
        end else if (sig_clr) begin
            sig_q <= 12'h000;
        end else if (cap_we) begin
            sig_q <= {sig_q[10:0], sig_q[11]} ^ {9'b0, f, g, h};
        end
    end

    assign sig = sig_q;
`else
    assign sig = 12'h000;
`endif

endmodule

// File: doc/truth_table_sequencer.md
TRUTH_TABLE_SEQUENCER -- requirements
Module: truth_table_sequencer

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 The block SHALL have parameter SETTLE_CYCLES, default 1, giving the wait cycles (0..15) between applying a vector and sampling the datapath.
REQ-003 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: begin an exhaustive 16-vector scan.
REQ-006 The block SHALL have port abort, input, 1 bit: cancel a scan in progress.
REQ-007 The block SHALL have ports f, g, h, input, 1 bit each: outputs of the combinational 4-input datapath under control.
REQ-008 The block SHALL have ports a, b, c, d, output, 1 bit each: datapath inputs, where a is the vector MSB and d is the LSB.
REQ-009 The block SHALL have port busy, output, 1 bit: a scan is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: a scan completed and results are valid.
REQ-011 The block SHALL have port rd_addr, input, 4 bits: result-table read index.
REQ-012 The block SHALL have port rd_data, output, 3 bits: {f,g,h} captured for vector rd_addr.
REQ-013 The block SHALL have port sig, output, 12 bits: running signature of captured results.

Function
REQ-014 The block SHALL implement the states IDLE, APPLY, SETTLE, CAPTURE and DONE.
REQ-015 IDLE or DONE with start=1 SHALL move to APPLY, clear done, zero the vector index idx and sig, and drive {a,b,c,d}=idx on the same edge.
REQ-016 APPLY SHALL last 1 cycle, then go to SETTLE, or to CAPTURE when SETTLE_CYCLES=0.
REQ-017 SETTLE SHALL last exactly SETTLE_CYCLES cycles, counted by a 4-bit down-counter, then go to CAPTURE.
REQ-018 CAPTURE SHALL last 1 cycle; on the edge leaving it, {f,g,h} SHALL be written to table entry idx.
REQ-019 From CAPTURE with idx<15, the next state SHALL be APPLY with idx+1 driven on a..d; with idx=15, the next state SHALL be DONE.
REQ-020 Each vector SHALL take SETTLE_CYCLES+2 cycles, so done rises 16*(SETTLE_CYCLES+2) edges after the edge that sampled start.
REQ-021 busy SHALL be 1 in APPLY, SETTLE and CAPTURE, and 0 otherwise.
REQ-022 done SHALL be 1 only in DONE and SHALL hold until start, abort or rst.
REQ-023 a, b, c, d SHALL be 0 in IDLE and DONE.
REQ-024 start while busy SHALL be ignored.
REQ-025 abort while busy SHALL force IDLE on the next edge; table entries already written are kept, and done stays 0.
REQ-026 abort in IDLE or DONE SHALL force IDLE, clearing done.
REQ-027 If start and abort are both high on the same edge, abort SHALL win.
REQ-028 rd_data SHALL be registered: it equals table[rd_addr] one cycle after rd_addr is presented, in any state.
REQ-029 A read of the entry being written on the same edge SHALL return the old value.
REQ-030 idx SHALL never wrap; the scan stops at 15.

Reset
REQ-031 With rst=1 at an edge, the block SHALL enter IDLE and clear idx, the settle counter, a, b, c, d, busy, done, sig, rd_data and all 16 table entries to 0.
REQ-032 rst SHALL take priority over start and abort.
REQ-033 rst mid-scan SHALL behave as for REQ-031, with no partial-result retention.

Configuration
REQ-034 Macro TTS_SIGNATURE_EN, when defined, SHALL make each CAPTURE edge update sig <= {sig[10:0],sig[11]} ^ {9'b0,f,g,h}.
REQ-035 With TTS_SIGNATURE_EN undefined, sig SHALL be tied to 12'h000, no signature register SHALL exist, and all other behaviour SHALL be identical.

Verification
REQ-036 With SETTLE_CYCLES=1 and the datapath modelled as f=a&b, g=c|d, h=a^d, one start pulse SHALL make done rise exactly 48 edges later, with busy high for 48 cycles.
REQ-037 After the REQ-036 scan, rd_addr=4'b1001 SHALL give rd_data=3'b010 next cycle, rd_addr=4'b1100 SHALL give 3'b101, and all 16 entries SHALL match the model.
REQ-038 With SETTLE_CYCLES=0, a scan SHALL take 32 edges, and a..d SHALL step 0..15, each value held 2 cycles.
REQ-039 abort asserted at edge 10 of a scan SHALL give IDLE next edge with busy=0, done=0 and a..d=0; entries for vectors already captured SHALL be retained and the rest SHALL be 0.
REQ-040 rst pulsed mid-scan SHALL clear all outputs and all table entries to 0, and start pulses while busy SHALL not restart or lengthen the scan.
REQ-041 With TTS_SIGNATURE_EN defined, sig SHALL equal the bench reference model after the REQ-036 scan; with f=g=h=0, sig SHALL be 12'h000; with the macro undefined, sig SHALL always be 12'h000.
